cardinal_nic: RTL
=================

// Module: cardinal_nic
// PURPOSE
//  Network interface between a processor and one PE port of the cardinal_router mesh.
//  - TX: the processor writes 64-bit packets into an output FIFO; the NIC injects them into the router PE input (net_so/net_do/net_ri).
//  - RX: it accepts packets ejected by the router (net_si/net_di/net_ro) into an input FIFO.
//  - The processor pops the input FIFO through a 2-bit addressed register interface.
//  - One instance is placed per mesh node, indexed idx = y*COLS + x.
// PARAMETERS
//  DATA_W   64  packet width; bit DATA_W-1 is the VC bit
//  DEPTH    2   entries per FIFO (power of 2, >=1)
// PORTS
//  clk           in   1       rising-edge clock
//  reset         in   1       synchronous, active-high
//  addr          in   2       00 RX data, 01 RX status, 10 TX data, 11 TX status
//  d_in          in   DATA_W  processor write data
//  d_out         out  DATA_W  processor read data (registered)
//  nic_en        in   1       access strobe
//  nic_wr_en     in   1       1 write, 0 read (qualified by nic_en)
//  net_so        out  1       NIC->router valid (to router pe_si)
//  net_do        out  DATA_W  NIC->router data (to router pe_di)
//  net_ro        in   1       router ready for NIC (from router pe_ri)
//  net_si        in   1       router->NIC valid (from router pe_so)
//  net_di        in   DATA_W  router->NIC data (from router pe_do)
//  net_ri        out  1       NIC ready for router (to router pe_ro)
//  net_polarity  in   1       router phase (from router polarity)
// BEHAVIOUR
//  Reset (sync, clk edge with reset=1):
//   - Both FIFOs empty, pointers 0; d_out=0.
//   - While reset=1: net_so=0 and net_ri=0. First cycle after reset: net_ri=1, net_so=0.
//  RX path:
//   - net_ri = ~rx_full.
//   - Push net_di when net_si & net_ri.
//   - net_si while full is ignored; the router must hold the packet.
//  TX path:
//   - net_do = tx head (0 when empty).
//   - net_so = tx_nonempty & net_ro & (head[DATA_W-1] != net_polarity). Combinational.
//   - Transfer occurs in any cycle net_so=1; the head pops at that edge.
//   - Packets whose VC bit equals net_polarity wait one phase.
//   - Strict FIFO order; no bypass of a stalled head.
//  Processor writes (nic_en & nic_wr_en):
//   - addr 10: push d_in if ~tx_full; dropped silently if full.
//   - Other addrs: no effect.
//  Processor reads (nic_en & ~nic_wr_en); d_out updates at the next edge, 1-cycle latency:
//   - 00: d_out = rx head; pop if nonempty. If empty, d_out=0 and no pop.
//   - 01: d_out = {0.., rx_nonempty}.
//   - 10: d_out = 0.
//   - 11: d_out = {0.., tx_full}.
//   - nic_en=0: d_out holds its value.
//  Simultaneous events:
//   - RX push and pop in the same cycle: both happen and occupancy is unchanged. A push while full is impossible because net_ri=0.
//   - TX processor push and net pop in the same cycle: both happen. A push is allowed only if ~tx_full at the start of the cycle.
//  Occupancy counters:
//   - Width clog2(DEPTH)+1; pointers wrap modulo DEPTH.
//   - full = (cnt==DEPTH); nonempty = (cnt!=0).
//  Reset mid-operation: all buffered packets are discarded; no partial transfer. net_so drops in the reset cycle.
// CONFIGURATION
//  CARDINAL_NIC_STATS_EN
//   - Defined: adds output ports tx_cnt[15:0] and rx_cnt[15:0], registered.
//     - tx_cnt increments on each net_so transfer; rx_cnt increments on each RX push.
//     - Both wrap at 16'hFFFF->0 and reset to 0.
//     - Status reads at 01/11 additionally place the count in d_out[31:16].
//   - Undefined: no extra ports or logic; d_out[DATA_W-1:1] reads 0 on status addresses.
// TESTING
//  1. Reset, then read 01 and 11 -> d_out=0 both; net_ri=1; net_so=0.
//  2. Write 10 with d_in=64'h0000_0000_0000_00A5, net_ro=1, net_polarity=1 -> net_so=1 with net_do=..A5 next cycle; tx empties; read 11 -> 0.
//  3. Write 10 with d_in=64'h8000_0000_0000_0001, net_polarity=1 -> net_so=0. Toggle net_polarity=0 -> net_so=1 and the packet transfers.
//  4. Drive net_si=1 with 64'h1111, 64'h2222, 64'h3333 on consecutive cycles (DEPTH=2) -> first two accepted, net_ri=0 on the third. Read 00 twice -> d_out 1111 then 2222. Third packet accepted once net_ri=1.
//  5. TX full (2 entries, net_ro=0); write 10 with 64'hDEAD -> dropped. Set net_ro=1 -> only the original two packets emerge, in order.
//  6. Reset asserted while tx holds 1 packet and rx holds 2 -> net_so=0 and net_ri=0 during reset; afterwards reads at 00 return 0. With STATS_EN: counters 0 after reset, and rx_cnt=2 after test 4's first two pushes.

Source files
------------

// File: rtl/cardinal_nic.sv
// Processor-to-mesh network interface: a TX FIFO injects packets into the router PE port, an RX FIFO
// absorbs ejected packets. Optional per-NIC packet counters are enabled with CARDINAL_NIC_STATS_EN.
module cardinal_nic #(
   parameter int DATA_W = 64,
   parameter int DEPTH  = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [1:0]        addr,
   input  logic [DATA_W-1:0] d_in,
   output logic [DATA_W-1:0] d_out,
   input  logic              nic_en,
   input  logic              nic_wr_en,
   output logic              net_so,
   output logic [DATA_W-1:0] net_do,
   input  logic              net_ro,
   input  logic              net_si,
   input  logic [DATA_W-1:0] net_di,
   output logic              net_ri,
   input  logic              net_polarity
`ifdef CARDINAL_NIC_STATS_EN
   ,
   output logic [15:0]       tx_cnt,
   output logic [15:0]       rx_cnt
`endif
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH) + 1;

   typedef enum logic [1:0] {
      ADDR_RX_DATA = 2'b00,
      ADDR_RX_STAT = 2'b01,
      ADDR_TX_DATA = 2'b10,
      ADDR_TX_STAT = 2'b11
   } addr_e;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   logic [DATA_W-1:0] tx_mem_q [DEPTH];
   logic [DATA_W-1:0] rx_mem_q [DEPTH];

   logic [PTR_W-1:0]  tx_wr_ptr_q, tx_wr_ptr_d, tx_rd_ptr_q, tx_rd_ptr_d;
   logic [PTR_W-1:0]  rx_wr_ptr_q, rx_wr_ptr_d, rx_rd_ptr_q, rx_rd_ptr_d;
   logic [CNT_W-1:0]  tx_occ_q, tx_occ_d, rx_occ_q, rx_occ_d;
   logic [DATA_W-1:0] d_out_q, d_out_d;

   addr_e             acc_addr;
   logic              rd_req, wr_req;
   logic              tx_full, tx_nonempty, rx_full, rx_nonempty;
   logic              tx_push, tx_pop, rx_push, rx_pop;
   logic [DATA_W-1:0] tx_head, rx_head;

`ifdef CARDINAL_NIC_STATS_EN
   logic [15:0]       tx_stat_q, tx_stat_d, rx_stat_q, rx_stat_d;
`endif

   // NOTE: every signal in an always_comb gets a value before any branch, so no latch can be inferred.
   always_comb begin
      acc_addr    = addr_e'(addr);
      rd_req      = nic_en & ~nic_wr_en;
      wr_req      = nic_en & nic_wr_en;

      tx_full     = (tx_occ_q == CNT_W'(DEPTH));
      tx_nonempty = (tx_occ_q != '0);
      rx_full     = (rx_occ_q == CNT_W'(DEPTH));
      rx_nonempty = (rx_occ_q != '0);
      tx_head     = tx_mem_q[tx_rd_ptr_q];
      rx_head     = rx_mem_q[rx_rd_ptr_q];

      // Both handshakes are forced low while reset is held so nothing crosses mid-reset.
      net_do      = tx_nonempty ? tx_head : '0;
      net_so      = ~reset & tx_nonempty & net_ro & (tx_head[DATA_W-1] != net_polarity);
      net_ri      = ~reset & ~rx_full;

      tx_push     = wr_req & (acc_addr == ADDR_TX_DATA) & ~tx_full;
      tx_pop      = net_so;
      rx_push     = net_si & net_ri;
      rx_pop      = rd_req & (acc_addr == ADDR_RX_DATA) & rx_nonempty;
   end

   always_comb begin
      tx_wr_ptr_d = tx_push ? ptr_inc(tx_wr_ptr_q) : tx_wr_ptr_q;
      tx_rd_ptr_d = tx_pop  ? ptr_inc(tx_rd_ptr_q) : tx_rd_ptr_q;
      rx_wr_ptr_d = rx_push ? ptr_inc(rx_wr_ptr_q) : rx_wr_ptr_q;
      rx_rd_ptr_d = rx_pop  ? ptr_inc(rx_rd_ptr_q) : rx_rd_ptr_q;
      tx_occ_d    = tx_occ_q + CNT_W'(tx_push) - CNT_W'(tx_pop);
      rx_occ_d    = rx_occ_q + CNT_W'(rx_push) - CNT_W'(rx_pop);

`ifdef CARDINAL_NIC_STATS_EN
      tx_stat_d   = tx_stat_q + 16'(tx_pop);
      rx_stat_d   = rx_stat_q + 16'(rx_push);
`endif

      d_out_d = d_out_q;
      if (rd_req) begin
         unique case (acc_addr)
            ADDR_RX_DATA: d_out_d = rx_nonempty ? rx_head : '0;
            ADDR_RX_STAT: begin
               d_out_d = DATA_W'(rx_nonempty);
`ifdef CARDINAL_NIC_STATS_EN
               d_out_d[31:16] = rx_stat_q;
`endif
            end
            ADDR_TX_DATA: d_out_d = '0;
            ADDR_TX_STAT: begin
               d_out_d = DATA_W'(tx_full);
`ifdef CARDINAL_NIC_STATS_EN
               d_out_d[31:16] = tx_stat_q;
`endif
            end
            default:      d_out_d = d_out_q;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         tx_wr_ptr_q <= '0;
         tx_rd_ptr_q <= '0;
         rx_wr_ptr_q <= '0;
         rx_rd_ptr_q <= '0;
         tx_occ_q    <= '0;
         rx_occ_q    <= '0;
         d_out_q     <= '0;
`ifdef CARDINAL_NIC_STATS_EN
         tx_stat_q   <= '0;
         rx_stat_q   <= '0;
`endif
      end else begin
         tx_wr_ptr_q <= tx_wr_ptr_d;
         tx_rd_ptr_q <= tx_rd_ptr_d;
         rx_wr_ptr_q <= rx_wr_ptr_d;
         rx_rd_ptr_q <= rx_rd_ptr_d;
         tx_occ_q    <= tx_occ_d;
         rx_occ_q    <= rx_occ_d;
         d_out_q     <= d_out_d;
`ifdef CARDINAL_NIC_STATS_EN
         tx_stat_q   <= tx_stat_d;
         rx_stat_q   <= rx_stat_d;
`endif
      end
   end

   // NOTE: FIFO storage is deliberately not reset; occupancy gates every read, so stale words are never seen.
   always_ff @(posedge clk) begin
      if (tx_push) tx_mem_q[tx_wr_ptr_q] <= d_in;
      if (rx_push) rx_mem_q[rx_wr_ptr_q] <= net_di;
   end

   assign d_out  = d_out_q;
`ifdef CARDINAL_NIC_STATS_EN
   assign tx_cnt = tx_stat_q;
   assign rx_cnt = rx_stat_q;
`endif

endmodule
